// File: rtl/ballot_pkg.sv
// ballot_pkg: shared types and helpers for the ballot front-end sequencer.
//   state_e        - sequencer states
//   CAND_A..CAND_D - candidate index constants (button1..button4)
//   cand_t         - decoded button vector {single-hot flag, index}
//   onehot_to_idx  - decodes a 4-bit button vector into cand_t
package ballot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_QUALIFY = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_CLOSED  = 3'd5
  } state_e;

  localparam logic [1:0] CAND_A = 2'd0;
  localparam logic [1:0] CAND_B = 2'd1;
  localparam logic [1:0] CAND_C = 2'd2;
  localparam logic [1:0] CAND_D = 2'd3;

  typedef struct packed {
    logic       single;
    logic [1:0] idx;
  } cand_t;

  // Index is only meaningful when single is set.
  function automatic cand_t onehot_to_idx(input logic [3:0] v);
    cand_t r;
    r.single = (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    case (v)
      4'b0010: r.idx = CAND_B;
      4'b0100: r.idx = CAND_C;
      4'b1000: r.idx = CAND_D;
      default: r.idx = CAND_A;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ballot_controller_press_qualifier.sv
// press_qualifier: counts consecutive edges on which the same single button
// is sampled high.
//   clk, rst   - clock, synchronous active-high reset
//   buttons    - {button4, button3, button2, button1}
//   restart    - clears the hold count this edge
//   single     - exactly one button is high now (combinational)
//   idx        - index of the button currently being held (registered)
//   qualified  - hold count reaches HOLD_CYCLES on this edge (combinational)
module press_qualifier
  import ballot_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buttons,
  input  logic       restart,
  output logic       single,
  output logic [1:0] idx,
  output logic       qualified
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  cand_t         cand_c;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;

  assign cand_c    = onehot_to_idx(buttons);
  assign single    = cand_c.single;
  assign idx       = idx_q;
  assign qualified = (cnt_d == HOLD_MAX);

  // Fresh single press loads 1 and latches its index; saturate at HOLD_MAX.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (restart || !cand_c.single) begin
      cnt_d = '0;
    end else if ((cnt_q == '0) || (cand_c.idx != idx_q)) begin
      cnt_d = HW'(1);
      idx_d = cand_c.idx;
    end else if (cnt_q != HOLD_MAX) begin
      cnt_d = cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= CAND_A;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/ballot_controller.sv
// ballot_controller: turns raw candidate buttons into one qualified vote
// pulse per armed session, times out abandoned sessions, and after close
// drives results mode and cycles the display through all candidates.
//   clk, rst            - clock, synchronous active-high reset
//   arm                 - officer arms a session (sampled in IDLE)
//   close_poll          - ends polling until reset
//   button1..button4    - candidate A..D buttons
//   vote_valid/vote_sel - one-cycle qualified vote and its candidate
//   mode                - 0 voting, 1 results
//   disp_sel            - candidate on display in results mode
//   busy                - session in progress
//   timeout             - one-cycle pulse when an armed session expires
module ballot_controller
  import ballot_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned DISP_CYCLES    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       close_poll,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic       vote_valid,
  output logic [1:0] vote_sel,
  output logic       mode,
  output logic [1:0] disp_sel,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DW = $clog2(DISP_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DISP_MAX = DW'(DISP_CYCLES);

  state_e        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [DW-1:0] disp_cnt_q, disp_cnt_d;
  logic [1:0]    disp_sel_q, disp_sel_d;
  logic [1:0]    vote_sel_q, vote_sel_d;
  logic          vote_valid_q, vote_valid_d;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic [3:0]    btn_c;
  logic          same_c;
  logic          restart_c;
  logic          q_single;
  logic [1:0]    q_idx;
  logic          q_qualified;

  assign btn_c  = {button4, button3, button2, button1};
  // Exactly the latched button, nothing else.
  assign same_c = (btn_c == (4'b0001 << q_idx));
  // Hold count only survives while ARMED or while QUALIFY sees the same press.
  assign restart_c = !((state_q == ST_ARMED) ||
                       ((state_q == ST_QUALIFY) && same_c));

  press_qualifier #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_qual (
    .clk       (clk),
    .rst       (rst),
    .buttons   (btn_c),
    .restart   (restart_c),
    .single    (q_single),
    .idx       (q_idx),
    .qualified (q_qualified)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    disp_cnt_d   = disp_cnt_q;
    disp_sel_d   = disp_sel_q;
    vote_valid_d = 1'b0;
    vote_sel_d   = CAND_A;
    mode_d       = mode_q;
    timeout_d    = 1'b0;

    if (close_poll && (state_q != ST_CLOSED)) begin
      state_d    = ST_CLOSED;
      mode_d     = 1'b1;
      disp_cnt_d = '0;
      disp_sel_d = CAND_A;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d  = ST_ARMED;
            to_cnt_d = '0;
          end
        end
        ST_ARMED: begin
          if (q_single) begin
            state_d = ST_QUALIFY;
          end else begin
            if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_d == TO_MAX) begin
              timeout_d = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end
        ST_QUALIFY: begin
          if (!same_c) begin
            state_d = ST_ARMED;
          end else if (q_qualified) begin
            state_d      = ST_ISSUE;
            vote_valid_d = 1'b1;
            vote_sel_d   = q_idx;
          end
        end
        ST_ISSUE: state_d = ST_RELEASE;
        ST_RELEASE: begin
          if (btn_c == 4'b0000) state_d = ST_IDLE;
        end
        ST_CLOSED: begin
          disp_cnt_d = disp_cnt_q + DW'(1);
          if (disp_cnt_d == DISP_MAX) begin
            disp_cnt_d = '0;
            disp_sel_d = disp_sel_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_QUALIFY) ||
             (state_d == ST_ISSUE) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      to_cnt_q     <= '0;
      disp_cnt_q   <= '0;
      disp_sel_q   <= CAND_A;
      vote_valid_q <= 1'b0;
      vote_sel_q   <= CAND_A;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      disp_cnt_q   <= disp_cnt_d;
      disp_sel_q   <= disp_sel_d;
      vote_valid_q <= vote_valid_d;
      vote_sel_q   <= vote_sel_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign vote_valid = vote_valid_q;
  assign vote_sel   = vote_sel_q;
  assign mode       = mode_q;
  assign disp_sel   = disp_sel_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Bench for ballot_controller: table-driven directed rows, hand-written
// multi-cycle sequences and randomized traffic, all compared each cycle
// against a session-level reference model.
module tb_ballot_controller;

  localparam int HOLD = 10;
  localparam int TMO  = 1000;
  localparam int DISP = 50;

  logic       clk = 1'b0;
  logic       rst, arm, close_poll;
  logic [3:0] btn;
  logic       vote_valid, mode, busy, timeout;
  logic [1:0] vote_sel, disp_sel;

  always #5 clk = ~clk;

  ballot_controller #(
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .DISP_CYCLES(DISP)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .close_poll(close_poll),
    .button1(btn[0]), .button2(btn[1]), .button3(btn[2]), .button4(btn[3]),
    .vote_valid(vote_valid), .vote_sel(vote_sel), .mode(mode),
    .disp_sel(disp_sel), .busy(busy), .timeout(timeout)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a session is open, waiting on a press run, then a
  // one-cycle issue slot, then a wait for all buttons released.
  bit m_closed, m_sess, m_issue, m_rel;
  int m_age, m_run, m_idx, m_wait;
  bit m_vv, m_to;
  int m_vs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_vv = 1'b0; m_vs = 0; m_to = 1'b0;
    if (rst) begin
      m_closed = 0; m_age = 0; m_sess = 0; m_run = 0; m_idx = 0;
      m_wait = 0; m_issue = 0; m_rel = 0;
    end else if (close_poll && !m_closed) begin
      m_closed = 1; m_age = 0; m_sess = 0; m_run = 0; m_issue = 0; m_rel = 0;
    end else if (m_closed) begin
      m_age++;
    end else if (m_issue) begin
      m_issue = 0; m_rel = 1;
    end else if (m_rel) begin
      if (btn == 4'b0000) m_rel = 0;
    end else if (m_sess) begin
      if ($countones(btn) == 1 && (m_run == 0 || $clog2(btn) == m_idx)) begin
        m_idx = $clog2(btn);
        m_run++;
        if (m_run == HOLD) begin
          m_vv = 1; m_vs = m_idx; m_sess = 0; m_run = 0; m_issue = 1;
        end
      end else if (m_run > 0) begin
        m_run = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_to = 1; m_sess = 0;
        end
      end
    end else if (arm) begin
      m_sess = 1; m_wait = 0; m_run = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model_vote_valid", 32'(vote_valid), 32'(m_vv));
    chk("model_vote_sel",   32'(vote_sel),   32'(m_vs));
    chk("model_timeout",    32'(timeout),    32'(m_to));
    chk("model_busy",       32'(busy),       32'(m_sess || m_issue || m_rel));
    chk("model_mode",       32'(mode),       32'(m_closed));
    chk("model_disp_sel",   32'(disp_sel),   32'(m_closed ? (m_age / DISP) % 4 : 0));
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic drive(input logic r, input logic a, input logic c, input logic [3:0] b);
    rst = r; arm = a; close_poll = c; btn = b;
  endtask

  typedef struct {
    logic       r, a, c;
    logic [3:0] b;
    int         n;
    logic       vv;
    logic [1:0] vs;
    logic       busy;
    logic       mode;
    logic [1:0] disp;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  initial begin
    drive(1'b1, 1'b0, 1'b0, 4'b0000);

    //           r  a  c  btn    n   vv vs busy mode disp to
    tbl.push_back('{1, 0, 0, 4'h0, 2,  0, 0, 0, 0, 0, 0}); // reset
    tbl.push_back('{0, 1, 0, 4'h0, 1,  0, 0, 1, 0, 0, 0}); // basic vote
    tbl.push_back('{0, 0, 0, 4'h1, 9,  0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h1, 1,  1, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h1, 1,  0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h0, 1,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 4'h0, 1,  0, 0, 1, 0, 0, 0}); // glitch then hold
    tbl.push_back('{0, 0, 0, 4'h2, 4,  0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h0, 1,  0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h2, 10, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h0, 1,  0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h0, 1,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 4'h0, 1,  0, 0, 1, 0, 0, 0}); // multi-press
    tbl.push_back('{0, 0, 0, 4'h5, 20, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h4, 10, 1, 2, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h4, 1,  0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h0, 1,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h1, 15, 0, 0, 0, 0, 0, 0}); // no re-arm
    tbl.push_back('{0, 0, 0, 4'h0, 1,  0, 0, 0, 0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].a, tbl[i].c, tbl[i].b);
      run(tbl[i].n);
      chk($sformatf("row%0d_vote_valid", i), 32'(vote_valid), 32'(tbl[i].vv));
      chk($sformatf("row%0d_vote_sel", i),   32'(vote_sel),   32'(tbl[i].vs));
      chk($sformatf("row%0d_busy", i),       32'(busy),       32'(tbl[i].busy));
      chk($sformatf("row%0d_mode", i),       32'(mode),       32'(tbl[i].mode));
      chk($sformatf("row%0d_disp_sel", i),   32'(disp_sel),   32'(tbl[i].disp));
      chk($sformatf("row%0d_timeout", i),    32'(timeout),    32'(tbl[i].to));
    end

    // Timeout: armed with no press expires on the 1000th waiting edge.
    drive(1'b0, 1'b1, 1'b0, 4'h0); run(1);
    drive(1'b0, 1'b0, 1'b0, 4'h0); run(TMO - 1);
    chk("timeout_before", 32'(timeout), 32'd0);
    chk("busy_before_timeout", 32'(busy), 32'd1);
    run(1);
    chk("timeout_pulse", 32'(timeout), 32'd1);
    chk("busy_after_timeout", 32'(busy), 32'd0);
    run(1);
    chk("timeout_one_cycle", 32'(timeout), 32'd0);

    // Reset mid-qualify, then a normal vote.
    drive(1'b0, 1'b1, 1'b0, 4'h0); run(1);
    drive(1'b0, 1'b0, 1'b0, 4'h4); run(5);
    drive(1'b1, 1'b0, 1'b0, 4'h4); run(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vote_valid", 32'(vote_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'h4); run(3);
    chk("rst_no_vote", 32'(vote_valid), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 4'h0); run(1);
    drive(1'b0, 1'b0, 1'b0, 4'h2); run(HOLD);
    chk("post_rst_vote", 32'(vote_valid), 32'd1);
    chk("post_rst_sel", 32'(vote_sel), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 4'h0); run(2);

    // Close mid-qualify: no vote, results mode, display walks 0,1,2,3,0.
    drive(1'b0, 1'b1, 1'b0, 4'h0); run(1);
    drive(1'b0, 1'b0, 1'b0, 4'h8); run(5);
    drive(1'b0, 1'b0, 1'b1, 4'h8); run(1);
    chk("close_mode", 32'(mode), 32'd1);
    chk("close_no_vote", 32'(vote_valid), 32'd0);
    chk("close_busy", 32'(busy), 32'd0);
    chk("close_disp0", 32'(disp_sel), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 4'h8);
    for (int k = 1; k <= 4; k++) begin
      run(DISP - 1);
      chk($sformatf("disp_hold%0d", k), 32'(disp_sel), 32'((k - 1) % 4));
      run(1);
      chk($sformatf("disp_step%0d", k), 32'(disp_sel), 32'(k % 4));
    end
    chk("closed_no_vote", 32'(vote_valid), 32'd0);

    // Randomized traffic with occasional resets and closes.
    drive(1'b1, 1'b0, 1'b0, 4'h0); run(1);
    begin
      int hold_left = 0;
      logic [3:0] cur = 4'h0;
      for (int t = 0; t < 4000; t++) begin
        if (hold_left == 0) begin
          int r = $urandom_range(0, 9);
          if (r < 3)      cur = 4'h0;
          else if (r < 8) cur = 4'h1 << $urandom_range(0, 3);
          else            cur = 4'($urandom_range(0, 15));
          hold_left = $urandom_range(1, 14);
        end
        hold_left--;
        drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 1999) == 0), cur);
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ballot_controller.md
# ballot_controller

Front-end sequencer for the vote counter (`votingMachine`). It turns raw candidate buttons into qualified, one-per-session vote pulses, enforces officer arming, and times out abandoned sessions. After the poll closes, it drives `mode` and steps the result display through all four candidates. It sits between the panel I/O and the counter's `mode`/vote inputs.

## Interface
Parameters:
- `HOLD_CYCLES`, default 10: consecutive cycles a single button must be sampled high to qualify (≥2).
- `TIMEOUT_CYCLES`, default 1000: cycles an armed session may wait for a press.
- `DISP_CYCLES`, default 50: cycles each candidate stays on the display after close.

Ports (clock and reset first):
- `clk` in, 1: system clock, all logic on rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `arm` in, 1: officer arms one voter session (level; sampled only in IDLE).
- `close_poll` in, 1: ends polling permanently until reset.
- `button1`..`button4` in, 1 each: candidate A..D buttons, synchronous to `clk`.
- `vote_valid` out, 1: one-cycle qualified vote pulse.
- `vote_sel` out, 2: candidate index 0..3; valid while `vote_valid`=1, else 0.
- `mode` out, 1: 0 = voting, 1 = results; feeds counter `mode`.
- `disp_sel` out, 2: candidate shown in results mode; 0 while `mode`=0.
- `busy` out, 1: high in ARMED, QUALIFY, ISSUE, RELEASE.
- `timeout` out, 1: one-cycle pulse when an armed session expires.

## Operation
- States: IDLE, ARMED, QUALIFY, ISSUE, RELEASE, CLOSED.
- Priority each cycle: `rst` > `close_poll` > state transitions.
- IDLE: `arm`=1 → ARMED and clear the timeout counter. Buttons are ignored.
- ARMED: exactly one button high → QUALIFY with hold count 1, latching its index. Zero or several buttons high → stay and increment the timeout counter. Counter reaching `TIMEOUT_CYCLES` → pulse `timeout`, go to IDLE.
- QUALIFY: same single button still high → increment. Any change (release, different button, extra button) → back to ARMED; the timeout counter keeps running, not reset. Count reaching `HOLD_CYCLES` → ISSUE.
- ISSUE: `vote_valid`=1 and `vote_sel`=latched index for exactly one cycle, then RELEASE.
- RELEASE: wait until all buttons are low, then IDLE. Exactly one vote is issued per arming.
- CLOSED: entered from any state when `close_poll`=1. A partial qualify is discarded with no vote. If the state is ISSUE, the pulse in that cycle still completes. `mode`=1. `disp_sel` starts at 0, advances every `DISP_CYCLES`, wraps 3→0. The only exit is `rst`.
- Button index encoding: button1→0, button2→1, button3→2, button4→3.

## Timing
- Reset values: state IDLE, `vote_valid`=0, `vote_sel`=0, `mode`=0, `disp_sel`=0, `busy`=0, `timeout`=0. All counters are 0.
- All outputs are registered, with no combinational input-to-output path.
- Vote latency: if the first sampling edge of a button is edge k, `vote_valid` is high in the cycle after edge k+HOLD_CYCLES−1.
- `busy` rises one cycle after `arm` is sampled and falls one cycle after the all-low release is sampled.
- `mode` rises in the cycle after `close_poll` is sampled.
- `disp_sel` changes every `DISP_CYCLES` cycles after that.
- Reset mid-session: the next cycle is IDLE, and no vote or timeout pulse is emitted.
- Counter widths are `$clog2(param+1)` and saturate at their terminal value. They never wrap.

## Structure
- `ballot_pkg` holds:
  - the state enum;
  - candidate index constants `CAND_A`..`CAND_D`;
  - the helper function `onehot_to_idx` with its single-hot check.
- One natural sub-module, `press_qualifier`. It takes the 4-bit button vector and a restart signal. It outputs `single`, `idx`, and `qualified` (hold counter reached `HOLD_CYCLES`).
- The FSM, timeout counter and display counter stay in `ballot_controller`.

## Test plan
- **Basic vote:** arm, then hold button1 for 10 cycles (HOLD_CYCLES=10). Expect one `vote_valid` with `vote_sel`=0 after 10 sampling edges. After release, `busy`=0.
- **Short glitch and hold:** arm, button2 high for 4 cycles, low, then high for 10 cycles. Expect exactly one vote with `vote_sel`=1 and no vote from the glitch.
- **Multi-press and no re-arm:** arm, button1 and button3 held together for 20 cycles. Expect no vote. Then release button1 and hold button3 alone for 10 cycles → one vote with `vote_sel`=2. A second press without re-arming yields no vote.
- **Timeout:** arm with TIMEOUT_CYCLES=1000 and no press. Expect a `timeout` pulse on cycle 1000, return to IDLE, and no `vote_valid`.
- **Close mid-qualify:** arm, hold button4 for 5 cycles, assert `close_poll`. Expect no vote and `mode`=1 next cycle. `disp_sel` reads 0,1,2,3,0 at 50-cycle intervals.
- **Reset mid-session:** assert `rst` during QUALIFY. All outputs read their reset values the next cycle, and a following arm and hold votes normally.
